pmod_adc_reader: RTL and testbench
==================================

Name: pmod_adc_reader

Overview:
- SPI-style receiver for a dual-channel 12-bit serial ADC module (two AD7476-class converters sharing CS_N/SCLK, separate data lines).
- Counterpart to the DAC transmitter path: drives CS_N/SCLK, shifts in 16-bit frames on both data lines, and presents 12-bit samples to the AXI config register block.
- Runs on the AXI clock and supports single-shot or continuous conversion.

Parameters:
- CLK_DIV, 8: SCLK half-period in clock cycles; legal range 4..255; 8 gives 6.25 MHz at 100 MHz.
- QUIET_CYCLES, 6: minimum CS_N-high cycles between frames (at least 1).
- CNT_WIDTH, 32: width of the sample counter.

Ports:
- S_AXI_ACLK  in  1  system clock.
- S_AXI_ARESETN  in  1  synchronous active-low reset.
- start  in  1  single-cycle pulse; starts one frame when idle.
- continuous  in  1  level; while high, frames repeat back-to-back.
- adc_sdata0  in  1  serial data, channel 0 (asynchronous pin).
- adc_sdata1  in  1  serial data, channel 1 (asynchronous pin).
- adc_cs_n  out  1  converter chip select, active low.
- adc_sclk  out  1  serial clock; idles high.
- data0  out  12  last completed channel-0 sample.
- data1  out  12  last completed channel-1 sample.
- data_valid  out  1  one-cycle pulse when data0/data1 update.
- frame_err  out  1  set if either frame's 4 leading bits were not all zero; updates with data_valid.
- busy  out  1  high in every state except IDLE.
- sample_count  out  CNT_WIDTH  number of completed frames.

Behaviour:
- Reset (synchronous, S_AXI_ARESETN=0 sampled on a rising edge):
  - State goes to IDLE.
  - adc_cs_n=1, adc_sclk=1.
  - data0, data1, data_valid, frame_err, busy, sample_count, shift registers and divider counter all go to 0.
  - A reset mid-frame aborts immediately; no data_valid is produced.
- Input sync: adc_sdata0 and adc_sdata1 each pass through a 2-flop synchronizer. CLK_DIV≥4 keeps the sampling point at least 2 cycles after the converter's data edge.
- State machine: IDLE, CS_SETUP, SHIFT, CS_HOLD, QUIET.
  - IDLE: exit when start=1 or continuous=1. Go to CS_SETUP and drive adc_cs_n=0 on the next cycle.
  - CS_SETUP: hold adc_cs_n=0, adc_sclk=1 for CLK_DIV cycles, then go to SHIFT.
  - SHIFT: 16 SCLK periods, each CLK_DIV cycles low then CLK_DIV cycles high.
    - On the cycle adc_sclk goes 0→1, shift both synchronized data bits into their 16-bit registers, MSB first.
    - After the 16th high phase, go to CS_HOLD. Total SHIFT time is 32*CLK_DIV cycles.
  - CS_HOLD: adc_cs_n=1, adc_sclk=1 for CLK_DIV cycles. On the last cycle:
    - data0 ← sr0[11:0], data1 ← sr1[11:0].
    - frame_err ← |sr0[15:12] | |sr1[15:12].
    - sample_count increments, wrapping to 0 after all-ones.
    - data_valid=1 for exactly that cycle.
    - Next state is QUIET.
  - QUIET: adc_cs_n=1 for QUIET_CYCLES cycles. Then go to CS_SETUP if continuous=1, else IDLE.
- Frame latency: start pulse to data_valid is 1 + 34*CLK_DIV cycles (273 at CLK_DIV=8).
- Continuous-mode period: 34*CLK_DIV + QUIET_CYCLES cycles.
- Boundary conditions:
  - start while busy: ignored; no queuing.
  - start and continuous both high in IDLE: same as continuous.
  - continuous dropped mid-frame: the current frame completes (data_valid still pulses), then QUIET, then IDLE.
  - data0/data1 hold their value between frames; they are never partially updated.
  - frame_err is not sticky; it reflects the latest frame only.
- Divider: one counter of width clog2(CLK_DIV). It reloads on every phase change and is held at 0 in IDLE and QUIET.

Decomposition:
- Package pmod_adc_pkg:
  - state enum (IDLE, CS_SETUP, SHIFT, CS_HOLD, QUIET).
  - constants FRAME_BITS=16, DATA_BITS=12, LEAD_ZEROS=4.
- Sub-module adc_shift_chan, instanced twice:
  - 2-flop synchronizer, 16-bit shift register with shift enable and clear.
  - Outputs the 12-bit payload and a lead-nonzero flag.
- The FSM, divider and counter stay in the top module.

Test Plan:
- Reset then idle: cs_n=1, sclk=1, all outputs 0, busy=0 for 100 cycles with no start.
- Single shot, CLK_DIV=8: ADC model drives 0x0ABC on ch0 and 0x0123 on ch1 (data changes on SCLK fall) → data_valid 273 cycles after start; data0=0xABC, data1=0x123, frame_err=0, sample_count=1, exactly 16 SCLK rising edges seen.
- Leading-bit error: ch1 frame 0xF001 → data1=0x001, frame_err=1. The next clean frame (0x0FFF) → frame_err=0, data1=0xFFF.
- Continuous mode, 3 frames, then continuous dropped during frame 3 → 3 data_valid pulses spaced 278 cycles apart; cs_n high ≥ QUIET_CYCLES+CLK_DIV between frames; busy falls after the 3rd QUIET; sample_count=3.
- start pulsed at cycle 50 of an active frame → ignored; only one data_valid.
- Reset asserted mid-SHIFT (bit 7) → next cycle cs_n=1, sclk=1, busy=0, no data_valid, data0/data1=0.

Source files
------------

// File: rtl/pmod_adc_pkg.sv
// Shared types and frame geometry for the dual-channel serial ADC reader.
package pmod_adc_pkg;

  typedef enum logic [2:0] {
    IDLE,
    CS_SETUP,
    SHIFT,
    CS_HOLD,
    QUIET
  } state_t;

  localparam int FRAME_BITS = 16;
  localparam int DATA_BITS  = 12;
  localparam int LEAD_ZEROS = 4;

  // The converter pads each frame with leading zeros; anything else means a bad frame.
  function automatic logic lead_nonzero(input logic [FRAME_BITS-1:0] frame);
    return |frame[FRAME_BITS-1 -: LEAD_ZEROS];
  endfunction

endpackage

// File: rtl/pmod_adc_reader_if.sv
// Control, serial pin and sample bundle between the ADC reader and its host/pins.
interface pmod_adc_reader_if
  import pmod_adc_pkg::*;
#(
  parameter int CNT_WIDTH = 32
);
  logic                  start;
  logic                  continuous;
  logic                  adc_sdata0;
  logic                  adc_sdata1;
  logic                  adc_cs_n;
  logic                  adc_sclk;
  logic [DATA_BITS-1:0]  data0;
  logic [DATA_BITS-1:0]  data1;
  logic                  data_valid;
  logic                  frame_err;
  logic                  busy;
  logic [CNT_WIDTH-1:0]  sample_count;

  modport master (
    input  start, continuous, adc_sdata0, adc_sdata1,
    output adc_cs_n, adc_sclk, data0, data1, data_valid, frame_err, busy, sample_count
  );

  modport slave (
    output start, continuous, adc_sdata0, adc_sdata1,
    input  adc_cs_n, adc_sclk, data0, data1, data_valid, frame_err, busy, sample_count
  );
endinterface

// File: rtl/pmod_adc_reader_shift_chan.sv
// One ADC data lane: 2-flop pin synchronizer feeding an MSB-first frame shift register.
module adc_shift_chan
  import pmod_adc_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 sdata,
  input  logic                 shift_en,
  input  logic                 clr,
  output logic [DATA_BITS-1:0] payload,
  output logic                 lead_nz
);
  logic                  sync_p0;
  logic                  sync_p1;
  logic [FRAME_BITS-1:0] sr;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync_p0 <= 1'b0;
      sync_p1 <= 1'b0;
      sr      <= '0;
    end else begin
      sync_p0 <= sdata;
      sync_p1 <= sync_p0;
      if (clr) begin
        sr <= '0;
      end else if (shift_en) begin
        sr <= {sr[FRAME_BITS-2:0], sync_p1};
      end
    end
  end

  assign payload = sr[DATA_BITS-1:0];
  assign lead_nz = lead_nonzero(sr);

endmodule

// File: rtl/pmod_adc_reader.sv
// Dual-channel 12-bit serial ADC reader: drives CS_N/SCLK, captures 16-bit frames on
// both data lines and publishes the payloads with a valid pulse and a frame counter.
module pmod_adc_reader
  import pmod_adc_pkg::*;
#(
  parameter int CLK_DIV      = 8,
  parameter int QUIET_CYCLES = 6,
  parameter int CNT_WIDTH    = 32
) (
  input  logic              S_AXI_ACLK,
  input  logic              S_AXI_ARESETN,
  pmod_adc_reader_if.master bus
);
  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int QW    = (QUIET_CYCLES > 1) ? $clog2(QUIET_CYCLES) : 1;
  localparam int BIT_W = $clog2(FRAME_BITS);

  state_t               state;
  logic [DIV_W-1:0]     div_cnt;
  logic [QW-1:0]        quiet_cnt;
  logic [BIT_W-1:0]     bit_cnt;
  logic                 phase_end;
  logic                 shift_en;
  logic                 sr_clr;
  logic [DATA_BITS-1:0] payload0;
  logic [DATA_BITS-1:0] payload1;
  logic                 lead_nz0;
  logic                 lead_nz1;
  logic [CNT_WIDTH-1:0] count_next;

  assign phase_end  = (div_cnt == DIV_W'(CLK_DIV - 1));
  // Capture on the same edge that raises SCLK, i.e. the end of a low phase.
  assign shift_en   = (state == SHIFT) && phase_end && !bus.adc_sclk;
  assign sr_clr     = (state == CS_SETUP);
  assign count_next = bus.sample_count + CNT_WIDTH'(1);

  adc_shift_chan u_chan0 (
    .clk      (S_AXI_ACLK),
    .rst_n    (S_AXI_ARESETN),
    .sdata    (bus.adc_sdata0),
    .shift_en (shift_en),
    .clr      (sr_clr),
    .payload  (payload0),
    .lead_nz  (lead_nz0)
  );

  adc_shift_chan u_chan1 (
    .clk      (S_AXI_ACLK),
    .rst_n    (S_AXI_ARESETN),
    .sdata    (bus.adc_sdata1),
    .shift_en (shift_en),
    .clr      (sr_clr),
    .payload  (payload1),
    .lead_nz  (lead_nz1)
  );

  always_ff @(posedge S_AXI_ACLK) begin
    if (!S_AXI_ARESETN) begin
      state            <= IDLE;
      div_cnt          <= '0;
      quiet_cnt        <= '0;
      bit_cnt          <= '0;
      bus.adc_cs_n     <= 1'b1;
      bus.adc_sclk     <= 1'b1;
      bus.data0        <= '0;
      bus.data1        <= '0;
      bus.data_valid   <= 1'b0;
      bus.frame_err    <= 1'b0;
      bus.busy         <= 1'b0;
      bus.sample_count <= '0;
    end else begin
      bus.data_valid <= 1'b0;
      case (state)
        IDLE: begin
          div_cnt <= '0;
          if (bus.start || bus.continuous) begin
            state        <= CS_SETUP;
            bus.adc_cs_n <= 1'b0;
            bus.busy     <= 1'b1;
          end
        end

        CS_SETUP: begin
          if (phase_end) begin
            div_cnt      <= '0;
            bit_cnt      <= '0;
            bus.adc_sclk <= 1'b0;
            state        <= SHIFT;
          end else begin
            div_cnt <= div_cnt + DIV_W'(1);
          end
        end

        SHIFT: begin
          if (phase_end) begin
            div_cnt <= '0;
            if (!bus.adc_sclk) begin
              bus.adc_sclk <= 1'b1;
            end else if (bit_cnt == BIT_W'(FRAME_BITS - 1)) begin
              bus.adc_cs_n <= 1'b1;
              state        <= CS_HOLD;
            end else begin
              bit_cnt      <= bit_cnt + BIT_W'(1);
              bus.adc_sclk <= 1'b0;
            end
          end else begin
            div_cnt <= div_cnt + DIV_W'(1);
          end
        end

        CS_HOLD: begin
          if (phase_end) begin
            div_cnt          <= '0;
            quiet_cnt        <= '0;
            bus.data0        <= payload0;
            bus.data1        <= payload1;
            bus.frame_err    <= lead_nz0 | lead_nz1;
            bus.sample_count <= count_next;
            bus.data_valid   <= 1'b1;
            state            <= QUIET;
          end else begin
            div_cnt <= div_cnt + DIV_W'(1);
          end
        end

        QUIET: begin
          div_cnt <= '0;
          if (quiet_cnt == QW'(QUIET_CYCLES - 1)) begin
            quiet_cnt <= '0;
            if (bus.continuous) begin
              bus.adc_cs_n <= 1'b0;
              state        <= CS_SETUP;
            end else begin
              bus.busy <= 1'b0;
              state    <= IDLE;
            end
          end else begin
            quiet_cnt <= quiet_cnt + QW'(1);
          end
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pmod_adc_reader.sv
// Randomized frame-level bench for pmod_adc_reader with a serial ADC pin model.
module tb_pmod_adc_reader;
  localparam int CLK_DIV      = 8;
  localparam int QUIET_CYCLES = 6;
  localparam int CNT_WIDTH    = 32;
  localparam int LAT          = 1 + 34 * CLK_DIV;
  localparam int PERIOD       = 34 * CLK_DIV + QUIET_CYCLES;

  logic clk;
  logic rst_n;

  pmod_adc_reader_if #(.CNT_WIDTH(CNT_WIDTH)) bus ();

  pmod_adc_reader #(
    .CLK_DIV      (CLK_DIV),
    .QUIET_CYCLES (QUIET_CYCLES),
    .CNT_WIDTH    (CNT_WIDTH)
  ) dut (
    .S_AXI_ACLK    (clk),
    .S_AXI_ARESETN (rst_n),
    .bus           (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_err    = 0;

  // Reference state: what the host should see after the last completed frame.
  logic [11:0] exp_d0   = '0;
  logic [11:0] exp_d1   = '0;
  logic        exp_ferr = 1'b0;
  int          exp_cnt  = 0;

  // Frames the ADC model will serve, one per CS_N assertion.
  logic [15:0] q0[$];
  logic [15:0] q1[$];

  int rises  = 0;
  int dv_cnt = 0;
  int cs_run = 0;
  int gap_q[$];

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Serial ADC: a new frame per CS_N fall, next bit (MSB first) after every SCLK fall.
  initial begin
    logic [15:0] cur0;
    logic [15:0] cur1;
    bus.adc_sdata0 = 1'b0;
    bus.adc_sdata1 = 1'b0;
    forever begin
      @(negedge bus.adc_cs_n);
      if (q0.size() > 0) begin
        cur0 = q0.pop_front();
        cur1 = q1.pop_front();
      end else begin
        cur0 = '0;
        cur1 = '0;
      end
      for (int k = 15; k >= 0; k--) begin
        @(negedge bus.adc_sclk or posedge bus.adc_cs_n);
        if (bus.adc_cs_n === 1'b1) break;
        bus.adc_sdata0 = cur0[k];
        bus.adc_sdata1 = cur1[k];
      end
    end
  end

  always @(posedge bus.adc_sclk) begin
    if (bus.adc_cs_n === 1'b0) rises++;
  end

  always @(negedge clk) begin
    if (bus.data_valid === 1'b1) dv_cnt++;
    if (bus.adc_cs_n === 1'b1) begin
      cs_run++;
    end else if (bus.adc_cs_n === 1'b0) begin
      if (cs_run > 0) gap_q.push_back(cs_run);
      cs_run = 0;
    end
  end

  task automatic expect_frame(input logic [15:0] v0, input logic [15:0] v1);
    exp_d0   = v0[11:0];
    exp_d1   = v1[11:0];
    exp_ferr = (v0[15:12] != 4'h0) || (v1[15:12] != 4'h0);
    exp_cnt++;
    chk("data0", bus.data0, exp_d0);
    chk("data1", bus.data1, exp_d1);
    chk("frame_err", bus.frame_err, exp_ferr);
    chk("sample_count", bus.sample_count, exp_cnt);
  endtask

  task automatic run_frame(input logic [15:0] v0, input logic [15:0] v1);
    int lat;
    int r0;
    q0.push_back(v0);
    q1.push_back(v1);
    r0 = rises;
    @(negedge clk);
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    lat = 1;
    while (bus.data_valid !== 1'b1 && lat < 1000) begin
      @(negedge clk);
      lat++;
      if (lat == 150) begin
        chk("hold_data0", bus.data0, exp_d0);
        chk("hold_data1", bus.data1, exp_d1);
        chk("busy_mid", bus.busy, 1'b1);
      end
    end
    chk("latency", lat, LAT);
    expect_frame(v0, v1);
    chk("sclk_rises", rises - r0, 16);
    @(negedge clk);
    chk("dv_pulse", bus.data_valid, 1'b0);
    repeat (QUIET_CYCLES + 1) @(negedge clk);
    chk("busy_done", bus.busy, 1'b0);
  endtask

  task automatic run_continuous();
    logic [15:0] f0 [3];
    logic [15:0] f1 [3];
    int t;
    int prev;
    int lim;
    int gsz;
    int dvb;
    gsz = gap_q.size();
    dvb = dv_cnt;
    for (int f = 0; f < 3; f++) begin
      f0[f] = 16'($urandom_range(0, 16'h0FFF));
      f1[f] = 16'($urandom());
      q0.push_back(f0[f]);
      q1.push_back(f1[f]);
    end
    @(negedge clk);
    bus.continuous = 1'b1;
    t    = 0;
    prev = 0;
    for (int f = 0; f < 3; f++) begin
      lim = t + 1000;
      @(negedge clk);
      t++;
      while (bus.data_valid !== 1'b1 && t < lim) begin
        if (f == 2 && t == prev + 100) bus.continuous = 1'b0;
        @(negedge clk);
        t++;
      end
      chk("cont_spacing", t - prev, (f == 0) ? LAT : PERIOD);
      expect_frame(f0[f], f1[f]);
      prev = t;
    end
    repeat (QUIET_CYCLES - 1) @(negedge clk);
    chk("cont_busy_quiet", bus.busy, 1'b1);
    @(negedge clk);
    chk("cont_busy_fall", bus.busy, 1'b0);
    chk("cont_gap_count", gap_q.size() - gsz, 3);
    if (gap_q.size() - gsz == 3) begin
      for (int i = 1; i < 3; i++)
        chk("cs_high_gap", gap_q[gsz + i] >= QUIET_CYCLES + CLK_DIV, 1'b1);
    end
    repeat (600) @(negedge clk);
    chk("cont_dv_total", dv_cnt - dvb, 3);
    chk("cont_count", bus.sample_count, exp_cnt);
  endtask

  initial begin
    int dvb;
    int r0;
    int n;
    logic [15:0] v0;
    logic [15:0] v1;
    rst_n          = 1'b0;
    bus.start      = 1'b0;
    bus.continuous = 1'b0;
    repeat (5) @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      chk("idle_ctrl", {bus.adc_cs_n, bus.adc_sclk, bus.busy, bus.data_valid, bus.frame_err},
          5'b11000);
      chk("idle_data", {bus.data0, bus.data1, bus.sample_count}, '0);
    end

    run_frame(16'h0ABC, 16'h0123);
    run_frame(16'h0555, 16'hF001);
    run_frame(16'h0AAA, 16'h0FFF);

    for (int i = 0; i < 6; i++) begin
      v0 = 16'($urandom());
      v1 = 16'($urandom());
      if ($urandom_range(0, 1) == 0) v0[15:12] = 4'h0;
      if ($urandom_range(0, 1) == 0) v1[15:12] = 4'h0;
      run_frame(v0, v1);
    end

    run_continuous();

    // A second start during an active frame must not queue another frame.
    dvb = dv_cnt;
    v0  = 16'($urandom_range(0, 16'h0FFF));
    v1  = 16'($urandom_range(0, 16'h0FFF));
    q0.push_back(v0);
    q1.push_back(v1);
    @(negedge clk);
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (48) @(negedge clk);
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    n = 0;
    while (bus.data_valid !== 1'b1 && n < 1000) begin
      @(negedge clk);
      n++;
    end
    expect_frame(v0, v1);
    repeat (700) @(negedge clk);
    chk("start_busy_dv", dv_cnt - dvb, 1);
    chk("start_busy_idle", bus.busy, 1'b0);

    // Abort mid-SHIFT after the seventh SCLK rise.
    dvb = dv_cnt;
    q0.push_back(16'h0FFF);
    q1.push_back(16'h0FFF);
    r0 = rises;
    @(negedge clk);
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    n = 0;
    while (rises - r0 < 7 && n < 1000) begin
      @(negedge clk);
      n++;
    end
    chk("abort_reached_bit7", rises - r0, 7);
    rst_n = 1'b0;
    @(negedge clk);
    chk("abort_ctrl", {bus.adc_cs_n, bus.adc_sclk, bus.busy, bus.data_valid, bus.frame_err},
        5'b11000);
    chk("abort_data", {bus.data0, bus.data1, bus.sample_count}, '0);
    rst_n    = 1'b1;
    exp_d0   = '0;
    exp_d1   = '0;
    exp_ferr = 1'b0;
    exp_cnt  = 0;
    repeat (600) @(negedge clk);
    chk("abort_no_dv", dv_cnt - dvb, 0);
    chk("abort_stays_idle", bus.busy, 1'b0);

    run_frame(16'h0321, 16'h0FED);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_err);
    $finish;
  end

endmodule
